spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 137 +++++++++++++
 tb/tb_spi_flash_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// SPI flash read master: sends CMD_READ and an 8-bit address, then shifts in data bytes.
// Define READ_BURST_EN to add the len port for 1..16 byte bursts; otherwise every read is one byte.
module spi_flash_reader #(
   parameter int          CLK_DIV  = 4,
   parameter logic [7:0]  CMD_READ = 8'h03
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] addr,
`ifdef READ_BURST_EN
   input  logic [3:0] len,
`endif
   output logic       busy,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done,
   output logic       cs,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, FINISH} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state, state_next;
   logic [7:0] div_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] addr_q;
   logic [7:0] shift_q;
   logic       byte_ready;
   logic       tick, shifting, sclk_rise, sclk_fall, byte_end, last_byte;

   assign tick      = (div_cnt == DIV_LAST);
   assign shifting  = (state == CMD) || (state == ADDR) || (state == DATA);
   assign sclk_rise = shifting && tick && !sclk;
   assign sclk_fall = shifting && tick && sclk;
   assign byte_end  = sclk_fall && (bit_cnt == 3'd7);
   assign busy      = (state != IDLE);

`ifdef READ_BURST_EN
   logic [3:0] byte_cnt;

   // Remaining bytes after the current one; reloaded from len on every accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= 4'd0;
      end else if (state == IDLE && start) begin
         byte_cnt <= len;
      end else if (state == DATA && byte_end && !last_byte) begin
         byte_cnt <= byte_cnt - 4'd1;
      end
   end

   assign last_byte = (byte_cnt == 4'd0);
`else
   assign last_byte = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)                  state_next = CMD;
         CMD:     if (byte_end)               state_next = ADDR;
         ADDR:    if (byte_end)               state_next = DATA;
         DATA:    if (byte_end && last_byte)  state_next = FINISH;
         FINISH:  if (tick)                   state_next = IDLE;
         default:                             state_next = IDLE;
      endcase
   end

   // Serial datapath: mosi moves on sclk rising edges so the flash sees it stable on falling edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs         <= 1'b1;
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         div_cnt    <= 8'd0;
         bit_cnt    <= 3'd0;
         addr_q     <= 8'd0;
         shift_q    <= 8'd0;
         byte_ready <= 1'b0;
         rd_data    <= 8'd0;
         rd_valid   <= 1'b0;
         done       <= 1'b0;
      end else begin
         rd_valid   <= 1'b0;
         done       <= 1'b0;
         byte_ready <= 1'b0;
         if (byte_ready) begin
            rd_data  <= shift_q;
            rd_valid <= 1'b1;
         end

         if (state == IDLE) begin
            div_cnt <= 8'd0;
            if (start) begin
               cs      <= 1'b0;
               mosi    <= CMD_READ[7];
               addr_q  <= addr;
               bit_cnt <= 3'd0;
            end
         end else begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
         end

         if (shifting && tick) sclk <= !sclk;

         if (sclk_rise) begin
            case (state)
               CMD:     mosi <= CMD_READ[3'd7 - bit_cnt];
               ADDR:    mosi <= addr_q[3'd7 - bit_cnt];
               default: begin
                  mosi       <= 1'b0;
                  shift_q    <= {shift_q[6:0], miso};
                  byte_ready <= (bit_cnt == 3'd7);
               end
            endcase
         end

         if (sclk_fall) bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;

         if (state == FINISH && tick) begin
            cs   <= 1'b1;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: one DUT at CLK_DIV=4 and one at CLK_DIV=2, each with a flash model.
// Burst scenario is compiled only when READ_BURST_EN is defined.
module tb_spi_flash_reader;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] start = '0;
   logic [1:0] busy, rd_valid, done, cs, sclk, mosi;
   logic [1:0] miso  = '0;
   logic [7:0] addr[2] = '{8'h00, 8'h00};
   logic [7:0] rd_data[2];
`ifdef READ_BURST_EN
   logic [3:0] len[2] = '{4'd0, 4'd0};
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] mem[256];
   logic [1:0] prev_cs   = 2'b11;
   logic [1:0] prev_sclk = 2'b00;
   logic [1:0] in_win    = 2'b00;
   int         lcnt[2]     = '{0, 0};
   int         hcnt[2]     = '{0, 0};
   int         last_low[2] = '{0, 0};
   int         last_high[2] = '{0, 0};
   int         cs_falls[2] = '{0, 0};
   int         fcnt[2]     = '{0, 0};
   int         run[2]      = '{0, 0};
   int         runs[2]     = '{0, 0};
   int         werr[2]     = '{0, 0};
   int         rv_cnt[2]   = '{0, 0};
   int         done_cnt[2] = '{0, 0};
   logic [7:0] fcmd[2]     = '{8'h00, 8'h00};
   logic [7:0] faddr[2]    = '{8'h00, 8'h00};
   logic [7:0] rv_log[2][16];

   always #5 clk = ~clk;

   spi_flash_reader #(.CLK_DIV(4), .CMD_READ(8'h03)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .addr(addr[0]),
`ifdef READ_BURST_EN
      .len(len[0]),
`endif
      .busy(busy[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .done(done[0]),
      .cs(cs[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0])
   );

   spi_flash_reader #(.CLK_DIV(2), .CMD_READ(8'h03)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .addr(addr[1]),
`ifdef READ_BURST_EN
      .len(len[1]),
`endif
      .busy(busy[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .done(done[1]),
      .cs(cs[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1])
   );

   // Flash model and bus monitor, sampled mid-cycle; the flash captures mosi and drives miso on sclk falls.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int         b;
         logic [7:0] cur;
         if (cs[i]) begin
            if (!prev_cs[i]) begin
               last_low[i] = lcnt[i];
               hcnt[i] = 0;
            end
            hcnt[i]++;
         end else begin
            if (prev_cs[i]) begin
               last_high[i] = hcnt[i];
               lcnt[i] = 0;
               fcnt[i] = 0;
               miso[i] = 1'b0;
               cs_falls[i]++;
            end
            lcnt[i]++;
            if (prev_sclk[i] && !sclk[i]) begin
               if (fcnt[i] < 8)       fcmd[i]  = {fcmd[i][6:0], mosi[i]};
               else if (fcnt[i] < 16) faddr[i] = {faddr[i][6:0], mosi[i]};
               fcnt[i]++;
               if (fcnt[i] >= 16) begin
                  b = fcnt[i] - 16;
                  cur = mem[8'(faddr[i] + 8'(b / 8))];
                  miso[i] = cur[7 - (b % 8)];
               end
            end
         end
         if (!cs[i]) begin
            if (in_win[i] && sclk[i] == prev_sclk[i]) begin
               run[i]++;
            end else begin
               if (in_win[i]) begin
                  runs[i]++;
                  if (run[i] != ((i == 0) ? 4 : 2)) werr[i]++;
               end
               run[i] = 1;
            end
            in_win[i] = 1'b1;
         end else if (in_win[i]) begin
            runs[i]++;
            if (run[i] != ((i == 0) ? 4 : 2)) werr[i]++;
            in_win[i] = 1'b0;
         end
         if (rd_valid[i]) begin
            rv_log[i][rv_cnt[i] % 16] = rd_data[i];
            rv_cnt[i]++;
         end
         if (done[i]) done_cnt[i]++;
         prev_cs[i]   = cs[i];
         prev_sclk[i] = sclk[i];
      end
   end

   task automatic issue_start(input int i, input logic [7:0] a);
      @(negedge clk);
      start[i] = 1'b1;
      addr[i]  = a;
      @(negedge clk);
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input string name);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (done[i]) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s done timeout: got no done pulse, expected one within 4000 cycles", name);
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (cs !== 2'b11)       begin errors++; $display("[TB] FAIL reset cs: got %b expected 11", cs); end
      checks++; if (sclk !== 2'b00)     begin errors++; $display("[TB] FAIL reset sclk: got %b expected 00", sclk); end
      checks++; if (mosi !== 2'b00)     begin errors++; $display("[TB] FAIL reset mosi: got %b expected 00", mosi); end
      checks++; if (busy !== 2'b00)     begin errors++; $display("[TB] FAIL reset busy: got %b expected 00", busy); end
      checks++; if ({rd_valid, done} !== 4'b0000) begin errors++; $display("[TB] FAIL reset pulses: got %b expected 0000", {rd_valid, done}); end
      checks++; if (rd_data[0] !== 8'h00) begin errors++; $display("[TB] FAIL reset rd_data: got %h expected 00", rd_data[0]); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      int rv0, dn0, w0, r0;
      rv0 = rv_cnt[0]; dn0 = done_cnt[0]; w0 = werr[0]; r0 = runs[0];
      issue_start(0, 8'h0A);
      #1;
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL single busy: got %b expected 1", busy[0]); end
      checks++; if (cs[0] !== 1'b0)   begin errors++; $display("[TB] FAIL single cs: got %b expected 0", cs[0]); end
      wait_done(0, "single");
      checks++; if (rd_data[0] !== 8'hDE)   begin errors++; $display("[TB] FAIL single rd_data: got %h expected de", rd_data[0]); end
      checks++; if (rv_cnt[0] - rv0 !== 1)  begin errors++; $display("[TB] FAIL single rd_valid count: got %0d expected 1", rv_cnt[0] - rv0); end
      checks++; if (done_cnt[0] - dn0 !== 1) begin errors++; $display("[TB] FAIL single done count: got %0d expected 1", done_cnt[0] - dn0); end
      checks++; if (fcmd[0] !== 8'h03)      begin errors++; $display("[TB] FAIL single cmd byte: got %h expected 03", fcmd[0]); end
      checks++; if (faddr[0] !== 8'h0A)     begin errors++; $display("[TB] FAIL single addr byte: got %h expected 0a", faddr[0]); end
      checks++; if (last_low[0] !== 196)    begin errors++; $display("[TB] FAIL single cs low: got %0d expected 196", last_low[0]); end
      checks++; if (werr[0] - w0 !== 0)     begin errors++; $display("[TB] FAIL single sclk widths: got %0d bad expected 0", werr[0] - w0); end
      checks++; if (runs[0] - r0 !== 49)    begin errors++; $display("[TB] FAIL single sclk halves: got %0d expected 49", runs[0] - r0); end
      @(negedge clk);
      #1;
      checks++; if ({busy[0], cs[0]} !== 2'b01) begin errors++; $display("[TB] FAIL single idle after: got %b expected 01", {busy[0], cs[0]}); end
   endtask

   task automatic test_busy_guard();
      int cf0;
      cf0 = cs_falls[0];
      issue_start(0, 8'h0C);
      repeat (80) @(negedge clk);
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL guard busy: got %b expected 1", busy[0]); end
      start[0] = 1'b1;
      addr[0]  = 8'h55;
      @(negedge clk);
      start[0] = 1'b0;
      addr[0]  = 8'h00;
      wait_done(0, "guard");
      checks++; if (rd_data[0] !== 8'hBE) begin errors++; $display("[TB] FAIL guard rd_data: got %h expected be", rd_data[0]); end
      checks++; if (faddr[0] !== 8'h0C)   begin errors++; $display("[TB] FAIL guard addr byte: got %h expected 0c", faddr[0]); end
      repeat (20) @(negedge clk);
      #1;
      checks++; if (cs_falls[0] - cf0 !== 1) begin errors++; $display("[TB] FAIL guard cs windows: got %0d expected 1", cs_falls[0] - cf0); end
   endtask

   task automatic test_reset_mid_data();
      int rv0, dn0;
      rv0 = rv_cnt[0]; dn0 = done_cnt[0];
      issue_start(0, 8'h0A);
      repeat (150) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({cs[0], sclk[0]} !== 2'b10) begin errors++; $display("[TB] FAIL abort cs/sclk: got %b expected 10", {cs[0], sclk[0]}); end
      checks++; if (busy[0] !== 1'b0)           begin errors++; $display("[TB] FAIL abort busy: got %b expected 0", busy[0]); end
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (rv_cnt[0] - rv0 !== 0)   begin errors++; $display("[TB] FAIL abort rd_valid: got %0d expected 0", rv_cnt[0] - rv0); end
      checks++; if (done_cnt[0] - dn0 !== 0) begin errors++; $display("[TB] FAIL abort done: got %0d expected 0", done_cnt[0] - dn0); end
      checks++; if (rd_data[0] !== 8'h00)    begin errors++; $display("[TB] FAIL abort rd_data: got %h expected 00", rd_data[0]); end
      issue_start(0, 8'h0B);
      wait_done(0, "after abort");
      checks++; if (rd_data[0] !== 8'hAD) begin errors++; $display("[TB] FAIL after abort rd_data: got %h expected ad", rd_data[0]); end
   endtask

   task automatic test_back_to_back();
      int rv0;
      rv0 = rv_cnt[0];
      issue_start(0, 8'h0A);
      wait_done(0, "b2b first");
      checks++; if (rd_data[0] !== 8'hDE) begin errors++; $display("[TB] FAIL b2b first rd_data: got %h expected de", rd_data[0]); end
      start[0] = 1'b1;
      addr[0]  = 8'h0B;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, "b2b second");
      checks++; if (last_high[0] !== 1)     begin errors++; $display("[TB] FAIL b2b cs high gap: got %0d expected 1", last_high[0]); end
      checks++; if (rd_data[0] !== 8'hAD)   begin errors++; $display("[TB] FAIL b2b second rd_data: got %h expected ad", rd_data[0]); end
      checks++; if (rv_cnt[0] - rv0 !== 2)  begin errors++; $display("[TB] FAIL b2b rd_valid count: got %0d expected 2", rv_cnt[0] - rv0); end
   endtask

   task automatic test_min_div();
      int w0, r0;
      w0 = werr[1]; r0 = runs[1];
      issue_start(1, 8'h0D);
      wait_done(1, "div2");
      checks++; if (rd_data[1] !== 8'hEF) begin errors++; $display("[TB] FAIL div2 rd_data: got %h expected ef", rd_data[1]); end
      checks++; if (faddr[1] !== 8'h0D)   begin errors++; $display("[TB] FAIL div2 addr byte: got %h expected 0d", faddr[1]); end
      checks++; if (werr[1] - w0 !== 0)   begin errors++; $display("[TB] FAIL div2 sclk widths: got %0d bad expected 0", werr[1] - w0); end
      checks++; if (runs[1] - r0 !== 49)  begin errors++; $display("[TB] FAIL div2 sclk halves: got %0d expected 49", runs[1] - r0); end
      checks++; if (last_low[1] !== 98)   begin errors++; $display("[TB] FAIL div2 cs low: got %0d expected 98", last_low[1]); end
   endtask

`ifdef READ_BURST_EN
   task automatic test_burst();
      int rv0, dn0;
      logic [7:0] exp_bytes[4];
      exp_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      rv0 = rv_cnt[0]; dn0 = done_cnt[0];
      len[0] = 4'd3;
      issue_start(0, 8'h0A);
      len[0] = 4'd0;
      wait_done(0, "burst");
      checks++; if (rv_cnt[0] - rv0 !== 4)   begin errors++; $display("[TB] FAIL burst rd_valid count: got %0d expected 4", rv_cnt[0] - rv0); end
      checks++; if (done_cnt[0] - dn0 !== 1) begin errors++; $display("[TB] FAIL burst done count: got %0d expected 1", done_cnt[0] - dn0); end
      checks++; if (last_low[0] !== 388)     begin errors++; $display("[TB] FAIL burst cs low: got %0d expected 388", last_low[0]); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rv_log[0][(rv0 + k) % 16] !== exp_bytes[k]) begin
            errors++;
            $display("[TB] FAIL burst byte %0d: got %h expected %h", k, rv_log[0][(rv0 + k) % 16], exp_bytes[k]);
         end
      end
   endtask
`endif

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'(a ^ 8'h5A);
      mem[8'h0A] = 8'hDE;
      mem[8'h0B] = 8'hAD;
      mem[8'h0C] = 8'hBE;
      mem[8'h0D] = 8'hEF;
      test_reset();
      test_single_read();
      test_busy_guard();
      test_reset_mid_data();
      test_back_to_back();
      test_min_div();
`ifdef READ_BURST_EN
      test_burst();
`endif
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
